// File: rtl/mic_steer_controller.sv
// Mic front-end sequencer: settle, sample the phase comparator over fixed windows,
// majority-vote into a steering decision with deadband, and track tone loss.
module mic_steer_controller #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int SAMPLE_PERIOD = 50,
    parameter int NUM_SAMPLES   = 64,
    parameter int MARGIN        = 8,
    parameter int LOST_WINDOWS  = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic Enable,
    input  logic Direction,
    input  logic RightMic,
    input  logic LeftMic,
    output logic MicEnable,
    output logic TurnLeft,
    output logic TurnRight,
    output logic Centered,
    output logic DecisionValid,
    output logic SignalLost
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int NW = $clog2(NUM_SAMPLES + 1);
    localparam int LW = $clog2(LOST_WINDOWS + 1);
    localparam int HI = NUM_SAMPLES / 2 + MARGIN;
    localparam int LO = NUM_SAMPLES / 2 - MARGIN;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_t;

    state_t state, state_nxt;

    logic [1:0]    dir_sync;
    logic [2:0]    rm_sync, lm_sync;
    logic [SW-1:0] settle_cnt;
    logic [PW-1:0] per_cnt;
    logic [NW-1:0] samp_cnt, rcount;
    logic [LW-1:0] lost_cnt, lost_nxt;
    logic          rise_r, rise_l;
    logic          dir_s, rm_rise, lm_rise;
    logic          settle_done, sample_tick, last_sample, win_active;

    // Third stage of the mic synchronisers doubles as the edge-detect history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dir_sync <= '0;
            rm_sync  <= '0;
            lm_sync  <= '0;
        end else begin
            dir_sync <= {dir_sync[0], Direction};
            rm_sync  <= {rm_sync[1:0], RightMic};
            lm_sync  <= {lm_sync[1:0], LeftMic};
        end
    end

    assign dir_s       = dir_sync[1];
    assign rm_rise     = rm_sync[1] & ~rm_sync[2];
    assign lm_rise     = lm_sync[1] & ~lm_sync[2];
    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign sample_tick = (per_cnt == PW'(SAMPLE_PERIOD - 1));
    assign last_sample = (samp_cnt == NW'(NUM_SAMPLES - 1));
    assign win_active  = rise_r & rise_l;
    assign lost_nxt    = (lost_cnt == LW'(LOST_WINDOWS)) ? lost_cnt : lost_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        MicEnable = (state != IDLE);
        case (state)
            IDLE:    if (Enable) state_nxt = SETTLE;
            SETTLE:  if (!Enable) state_nxt = IDLE;
                     else if (settle_done) state_nxt = SAMPLE;
            SAMPLE:  if (!Enable) state_nxt = IDLE;
                     else if (sample_tick && last_sample) state_nxt = DECIDE;
            DECIDE:  state_nxt = Enable ? SAMPLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            settle_cnt    <= '0;
            per_cnt       <= '0;
            samp_cnt      <= '0;
            rcount        <= '0;
            lost_cnt      <= '0;
            rise_r        <= 1'b0;
            rise_l        <= 1'b0;
            TurnLeft      <= 1'b0;
            TurnRight     <= 1'b0;
            Centered      <= 1'b0;
            DecisionValid <= 1'b0;
            SignalLost    <= 1'b0;
        end else begin
            DecisionValid <= 1'b0;
            if (state != IDLE && !Enable) begin
                // Abort: partial window and steering history are discarded.
                settle_cnt <= '0;
                per_cnt    <= '0;
                samp_cnt   <= '0;
                rcount     <= '0;
                lost_cnt   <= '0;
                rise_r     <= 1'b0;
                rise_l     <= 1'b0;
                TurnLeft   <= 1'b0;
                TurnRight  <= 1'b0;
                Centered   <= 1'b0;
                SignalLost <= 1'b0;
            end else begin
                case (state)
                    IDLE: settle_cnt <= '0;
                    SETTLE: begin
                        settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
                        if (settle_done) begin
                            per_cnt  <= '0;
                            samp_cnt <= '0;
                            rcount   <= '0;
                            rise_r   <= 1'b0;
                            rise_l   <= 1'b0;
                        end
                    end
                    SAMPLE: begin
                        per_cnt <= sample_tick ? '0 : per_cnt + 1'b1;
                        if (sample_tick) begin
                            samp_cnt <= samp_cnt + 1'b1;
                            rcount   <= rcount + NW'(dir_s);
                        end
                        rise_r <= rise_r | rm_rise;
                        rise_l <= rise_l | lm_rise;
                    end
                    DECIDE: begin
                        per_cnt  <= '0;
                        samp_cnt <= '0;
                        rcount   <= '0;
                        rise_r   <= 1'b0;
                        rise_l   <= 1'b0;
                        if (win_active) begin
                            lost_cnt      <= '0;
                            SignalLost    <= 1'b0;
                            TurnRight     <= (int'(rcount) > HI);
                            TurnLeft      <= (int'(rcount) < LO);
                            Centered      <= (int'(rcount) <= HI) && (int'(rcount) >= LO);
                            DecisionValid <= 1'b1;
                        end else begin
                            // Silent window: hold steering until the loss threshold.
                            lost_cnt <= lost_nxt;
                            if (lost_nxt == LW'(LOST_WINDOWS)) begin
                                SignalLost <= 1'b1;
                                TurnLeft   <= 1'b0;
                                TurnRight  <= 1'b0;
                                Centered   <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mic_steer_controller.sv
// Scoreboard bench for mic_steer_controller with small test parameters.
module tb_mic_steer_controller;

    localparam int SETTLE_CYCLES = 4;
    localparam int SAMPLE_PERIOD = 2;
    localparam int NUM_SAMPLES   = 8;
    localparam int MARGIN        = 1;
    localparam int LOST_WINDOWS  = 2;

    logic CLK = 1'b0;
    logic RST_N, Enable, Direction, RightMic, LeftMic;
    logic MicEnable, TurnLeft, TurnRight, Centered, DecisionValid, SignalLost;

    int checks = 0;
    int errors = 0;

    // Expected {TurnLeft, TurnRight, Centered, SignalLost} per decision pulse.
    logic [3:0] exp_q[$];
    logic       pend;
    logic       pend_dv;
    logic [3:0] pend_out;

    mic_steer_controller #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .NUM_SAMPLES  (NUM_SAMPLES),
        .MARGIN       (MARGIN),
        .LOST_WINDOWS (LOST_WINDOWS)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Enable       (Enable),
        .Direction    (Direction),
        .RightMic     (RightMic),
        .LeftMic      (LeftMic),
        .MicEnable    (MicEnable),
        .TurnLeft     (TurnLeft),
        .TurnRight    (TurnRight),
        .Centered     (Centered),
        .DecisionValid(DecisionValid),
        .SignalLost   (SignalLost)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one-hot steering every cycle, and pop/compare on each decision pulse.
    always @(negedge CLK) begin
        logic [3:0] e;
        if (RST_N === 1'b1) begin
            checks++;
            if ($countones({TurnLeft, TurnRight, Centered}) > 1) begin
                errors++;
                $display("FAIL onehot: got L%b R%b C%b expected at most one set at %0t",
                         TurnLeft, TurnRight, Centered, $time);
            end
            if (DecisionValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dv: got DecisionValid=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("decision", {4'b0, TurnLeft, TurnRight, Centered, SignalLost}, {4'b0, e});
                end
            end
        end
    end

    // Checks for the window that just decided, run on the cycle after its DECIDE.
    task automatic do_pending();
        if (pend) begin
            pend = 1'b0;
            chk("dv_timing", {7'b0, DecisionValid}, {7'b0, pend_dv});
            if (!pend_dv)
                chk("silent_out", {4'b0, TurnLeft, TurnRight, Centered, SignalLost}, {4'b0, pend_out});
        end
    endtask

    // Called one cycle before the window's first SAMPLE cycle; Direction for sample j
    // is held for the two cycles that land in the synchroniser at that sample.
    task automatic run_window(input logic [7:0] bits, input bit l_on, input int nsamp);
        bit first;
        first = 1'b1;
        for (int j = 0; j < nsamp; j++) begin
            Direction = bits[j];
            for (int k = 0; k < 2; k++) begin
                if (j < 6) begin
                    RightMic = ~RightMic;
                    if (l_on) LeftMic = ~LeftMic;
                end
                @(negedge CLK);
                if (first) begin
                    first = 1'b0;
                    do_pending();
                end
            end
        end
        if (nsamp == NUM_SAMPLES) @(negedge CLK);
    endtask

    task automatic expect_dv(input logic [3:0] outs);
        exp_q.push_back(outs);
    endtask

    task automatic set_pend(input logic dv, input logic [3:0] outs);
        pend     = 1'b1;
        pend_dv  = dv;
        pend_out = outs;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad;
        RST_N = 1'b0; Enable = 1'b0; Direction = 1'b0; RightMic = 1'b0; LeftMic = 1'b0;
        pend = 1'b0; pend_dv = 1'b0; pend_out = '0;
        repeat (3) @(negedge CLK);
        chk("reset_out", {2'b0, MicEnable, TurnLeft, TurnRight, Centered, DecisionValid, SignalLost}, 8'h00);
        RST_N = 1'b1;
        idle_bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if ({MicEnable, TurnLeft, TurnRight, Centered, DecisionValid, SignalLost} !== 6'b0) idle_bad++;
        end
        chk("idle_50", 8'(idle_bad), 8'h00);

        Enable = 1'b1;
        @(negedge CLK);
        chk("mic_enable", {7'b0, MicEnable}, 8'h01);
        repeat (SETTLE_CYCLES - 1) @(negedge CLK);

        expect_dv(4'b0100); run_window(8'b1101_1011, 1'b1, 8); set_pend(1'b1, '0); // 6 -> right
        expect_dv(4'b0010); run_window(8'b1010_0101, 1'b1, 8); set_pend(1'b1, '0); // 4 -> center
        expect_dv(4'b0010); run_window(8'b0001_1111, 1'b1, 8); set_pend(1'b1, '0); // 5 = HI -> center
        expect_dv(4'b0010); run_window(8'b0000_0111, 1'b1, 8); set_pend(1'b1, '0); // 3 = LO -> center
        expect_dv(4'b1000); run_window(8'b0100_0010, 1'b1, 8); set_pend(1'b1, '0); // 2 -> left
        run_window(8'hFF, 1'b0, 8); set_pend(1'b0, 4'b1000);                       // silent, hold left
        run_window(8'hFF, 1'b0, 8); set_pend(1'b0, 4'b0001);                       // lost
        expect_dv(4'b0100); run_window(8'b1110_1110, 1'b1, 8); set_pend(1'b1, '0); // recovered, right

        run_window(8'hFF, 1'b1, 5);
        Enable = 1'b0;
        @(negedge CLK);
        chk("enable_drop", {2'b0, MicEnable, TurnLeft, TurnRight, Centered, DecisionValid, SignalLost}, 8'h00);
        Enable = 1'b1;
        @(negedge CLK);
        chk("reenable_mic", {7'b0, MicEnable}, 8'h01);
        repeat (SETTLE_CYCLES - 1) @(negedge CLK);
        expect_dv(4'b1000); run_window(8'b1000_0001, 1'b1, 8); set_pend(1'b1, '0); // 2 -> left

        run_window(8'hFF, 1'b1, 3);
        #2 RST_N = 1'b0;
        #1 chk("async_rst", {2'b0, MicEnable, TurnLeft, TurnRight, Centered, DecisionValid, SignalLost}, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_mic", {7'b0, MicEnable}, 8'h01);
        repeat (SETTLE_CYCLES - 1) @(negedge CLK);
        expect_dv(4'b0010); run_window(8'b0011_1100, 1'b1, 8); set_pend(1'b1, '0); // 4 -> center
        @(negedge CLK);
        do_pending();
        repeat (5) @(negedge CLK);
        chk("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
